// File: rtl/axi_full_burst_slave_mem.sv
// AXI4 full-protocol slave backed by a word-addressed memory with FIXED/INCR/WRAP bursts,
// byte strobes, independent read/write engines and SLVERR on out-of-range or malformed bursts.
module axi_full_burst_slave_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  // Reserved burst type, or WRAP with a length that is not 2/4/8/16 beats.
  function automatic logic f_malformed(input logic [1:0] burst, input logic [7:0] len);
    logic bad;
    bad = 1'b0;
    if (burst == 2'b11) begin
      bad = 1'b1;
    end else if (burst == 2'b10) begin
      bad = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  function automatic logic [IDX_W-1:0] f_next_idx(input logic [IDX_W-1:0] idx,
                                                  input logic [7:0] len,
                                                  input logic [1:0] burst);
    logic [IDX_W-1:0] mask;
    logic [IDX_W-1:0] inc;
    logic [IDX_W-1:0] nxt;
    mask = IDX_W'(len);
    inc  = idx + {{(IDX_W-1){1'b0}}, 1'b1};
    case (burst)
      2'b00: nxt = idx;
      2'b10: begin
        if (f_malformed(burst, len)) nxt = inc;
        else nxt = (idx & ~mask) | (inc & mask);
      end
      default: nxt = inc;
    endcase
    return nxt;
  endfunction

  function automatic logic f_in_range(input logic [IDX_W-1:0] idx);
    return (idx >> MEM_AW) == {IDX_W{1'b0}};
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  wstate_t           r_wstate, w_wstate_nxt;
  logic [IDX_W-1:0]  r_widx;
  logic [7:0]        r_wlen, r_wcnt;
  logic [1:0]        r_wburst, r_bresp;
  logic              r_werr, r_awready, r_wready, r_bvalid;
  logic              w_aw_hs, w_w_hs, w_b_hs, w_wlast_beat, w_w_inrange, w_wbeat_err;

  rstate_t           r_rstate, w_rstate_nxt;
  logic [IDX_W-1:0]  r_ridx, w_fetch_idx;
  logic [7:0]        r_rlen, r_rcnt, w_fetch_len, w_fetch_cnt;
  logic [1:0]        r_rburst, r_rresp, w_fetch_burst;
  logic [DATA_W-1:0] r_rdata;
  logic              r_arready, r_rvalid, r_rlast;
  logic              w_ar_hs, w_r_hs, w_fetch_en, w_fetch_inrange, w_fetch_bad;
  logic              w_unused;

  assign w_unused = ^{s_axi_awaddr[OFF_W-1:0], s_axi_araddr[OFF_W-1:0]};

  assign w_aw_hs      = r_awready & s_axi_awvalid;
  assign w_w_hs       = r_wready & s_axi_wvalid;
  assign w_b_hs       = r_bvalid & s_axi_bready;
  assign w_wlast_beat = (r_wcnt == r_wlen);
  assign w_w_inrange  = f_in_range(r_widx);
  assign w_wbeat_err  = !w_w_inrange || (s_axi_wlast != w_wlast_beat);

  // Write FSM next state; the beat count, not wlast, closes the burst.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: if (w_aw_hs) w_wstate_nxt = W_DATA; else w_wstate_nxt = W_IDLE;
      W_DATA: if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP; else w_wstate_nxt = W_DATA;
      W_RESP: if (w_b_hs) w_wstate_nxt = W_IDLE; else w_wstate_nxt = W_RESP;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write state, burst context and registered handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate  <= W_IDLE;
      r_widx    <= {IDX_W{1'b0}};
      r_wlen    <= 8'd0;
      r_wcnt    <= 8'd0;
      r_wburst  <= 2'b00;
      r_werr    <= 1'b0;
      r_bresp   <= 2'b00;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE);
      r_wready  <= (w_wstate_nxt == W_DATA);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      if (w_aw_hs) begin
        r_widx   <= s_axi_awaddr[ADDR_W-1:OFF_W];
        r_wlen   <= s_axi_awlen;
        r_wburst <= s_axi_awburst;
        r_wcnt   <= 8'd0;
        r_werr   <= f_malformed(s_axi_awburst, s_axi_awlen);
      end else if (w_w_hs) begin
        r_widx <= f_next_idx(r_widx, r_wlen, r_wburst);
        r_wcnt <= r_wcnt + 8'd1;
        r_werr <= r_werr | w_wbeat_err;
        if (w_wlast_beat) r_bresp <= (r_werr | w_wbeat_err) ? 2'b10 : 2'b00;
      end
    end
  end

  // Memory byte writes; deliberately unreset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_w_hs && w_w_inrange) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) r_mem[r_widx[MEM_AW-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign w_ar_hs    = r_arready & s_axi_arvalid;
  assign w_r_hs     = r_rvalid & s_axi_rready;
  assign w_fetch_en = w_ar_hs | (w_r_hs & !r_rlast);

  // Read FSM next state and fetch source: AR channel for beat 0, latched context afterwards.
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_fetch_idx   = r_ridx;
    w_fetch_len   = r_rlen;
    w_fetch_burst = r_rburst;
    w_fetch_cnt   = r_rcnt + 8'd1;
    if (r_rstate == R_IDLE) begin
      w_fetch_idx   = s_axi_araddr[ADDR_W-1:OFF_W];
      w_fetch_len   = s_axi_arlen;
      w_fetch_burst = s_axi_arburst;
      w_fetch_cnt   = 8'd0;
    end else begin
      w_fetch_cnt   = r_rcnt + 8'd1;
    end
    case (r_rstate)
      R_IDLE: if (w_ar_hs) w_rstate_nxt = R_DATA; else w_rstate_nxt = R_IDLE;
      R_DATA: if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE; else w_rstate_nxt = R_DATA;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign w_fetch_inrange = f_in_range(w_fetch_idx);
  assign w_fetch_bad     = f_malformed(w_fetch_burst, w_fetch_len);

  // Read state and output beat registers; a same-cycle write leaves the old word here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate  <= R_IDLE;
      r_ridx    <= {IDX_W{1'b0}};
      r_rlen    <= 8'd0;
      r_rcnt    <= 8'd0;
      r_rburst  <= 2'b00;
      r_rdata   <= {DATA_W{1'b0}};
      r_rresp   <= 2'b00;
      r_rlast   <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
      if (w_ar_hs) begin
        r_rlen   <= s_axi_arlen;
        r_rburst <= s_axi_arburst;
      end
      if (w_fetch_en) begin
        r_rdata <= w_fetch_inrange ? r_mem[w_fetch_idx[MEM_AW-1:0]] : {DATA_W{1'b0}};
        r_rresp <= (w_fetch_bad || !w_fetch_inrange) ? 2'b10 : 2'b00;
        r_rlast <= (w_fetch_cnt == w_fetch_len);
        r_rcnt  <= w_fetch_cnt;
        r_ridx  <= f_next_idx(w_fetch_idx, w_fetch_len, w_fetch_burst);
      end
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;

endmodule

// File: tb/tb_axi_full_burst_slave_mem.sv
// Randomised bench for axi_full_burst_slave_mem against a word-array reference model.
module tb_axi_full_burst_slave_mem;
  localparam int DEP = 256;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_mem [DEP];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] last_rdata;

  axi_full_burst_slave_mem dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_malformed(input logic [1:0] b, input int len);
    return (b == 2'b11) || ((b == 2'b10) && !(len inside {1, 3, 7, 15}));
  endfunction

  // Word index of beat k: FIXED holds, valid WRAP cycles inside its aligned block, else increments.
  function automatic longint beat_idx(input logic [31:0] addr, input int len, input logic [1:0] b, input int k);
    longint s;
    longint n;
    longint base;
    s = longint'(addr >> 2);
    n = longint'(len + 1);
    if (b == 2'b00) return s;
    if (b == 2'b10 && !is_malformed(b, len)) begin
      base = (s / n) * n;
      return base + ((s - base + k) % n);
    end
    return (s + k) % (longint'(1) << 30);
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] b,
                          input bit bad_last, input int bstall);
    bit         hs;
    bit         err;
    int         n;
    longint     idx;
    logic [1:0] got_resp;
    awaddr = addr; awlen = len[7:0]; awburst = b; awvalid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin hs = awready; @(posedge clk); #1; n++; end
    awvalid = 1'b0;
    check_eq("aw_hs", {31'd0, hs}, 32'd1);
    check_eq("wready_lat", {31'd0, wready}, 32'd1);
    for (int k = 0; k <= len; k++) begin
      wvalid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      wvalid = 1'b1; wdata = wd[k]; wstrb = ws[k];
      wlast = (k == len) ? !bad_last : 1'b0;
      hs = 1'b0; n = 0;
      while (!hs && n < 50) begin hs = wready; @(posedge clk); #1; n++; end
      if (!hs) check_eq("w_hs", {31'd0, hs}, 32'd1);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check_eq("bvalid_lat", {31'd0, bvalid}, 32'd1);
    got_resp = bresp;
    for (int i = 0; i < bstall; i++) begin
      @(posedge clk); #1;
      check_eq("b_hold", {29'd0, bvalid, bresp}, {29'd0, 1'b1, got_resp});
    end
    bready = 1'b1; hs = 1'b0; n = 0;
    while (!hs && n < 50) begin hs = bvalid; @(posedge clk); #1; n++; end
    bready = 1'b0;
    check_eq("aw_back", {30'd0, bvalid, awready}, 32'd1);
    err = is_malformed(b, len) || bad_last;
    for (int k = 0; k <= len; k++) begin
      idx = beat_idx(addr, len, b, k);
      if (idx < DEP) begin
        for (int y = 0; y < 4; y++)
          if (ws[k][y]) model_mem[int'(idx)][8*y +: 8] = wd[k][8*y +: 8];
      end else begin
        err = 1'b1;
      end
    end
    check_eq("bresp", {30'd0, got_resp}, err ? 32'd2 : 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] b, input int stall_beat);
    bit          hs;
    bit          inr;
    int          n;
    int          k;
    int          stalls;
    longint      idx;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    araddr = addr; arlen = len[7:0]; arburst = b; arvalid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin hs = arready; @(posedge clk); #1; n++; end
    arvalid = 1'b0;
    check_eq("ar_hs", {31'd0, hs}, 32'd1);
    k = 0; n = 0; stalls = 0;
    while (k <= len && n < 2000) begin
      idx = beat_idx(addr, len, b, k);
      inr = (idx < DEP);
      exp_data = inr ? model_mem[int'(idx)] : 32'd0;
      exp_resp = (is_malformed(b, len) || !inr) ? 2'b10 : 2'b00;
      check_eq("rvalid", {31'd0, rvalid}, 32'd1);
      check_eq("rdata", rdata, exp_data);
      check_eq("rresp", {30'd0, rresp}, {30'd0, exp_resp});
      check_eq("rlast", {31'd0, rlast}, {31'd0, (k == len)});
      last_rdata = rdata;
      if (k == stall_beat && stalls < 3) begin
        rready = 1'b0; stalls++;
      end else begin
        rready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      if (rready) k++;
      n++;
    end
    rready = 1'b0;
    check_eq("r_done", {30'd0, rvalid, arready}, 32'd1);
  endtask

  function automatic int pick_len(input logic [1:0] b);
    int opts [6] = '{1, 3, 7, 15, 2, 4};
    if (b == 2'b10) return opts[$urandom_range(0, 5)];
    return $urandom_range(0, 15);
  endfunction

  initial begin
    int          len;
    int          len2;
    logic [1:0]  b;
    logic [31:0] a;
    logic [31:0] a2;
    bit          hs;
    resetn = 1'b0;
    awaddr = 32'd0; awlen = 8'd0; awburst = 2'b00; awvalid = 1'b0;
    wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = 32'd0; arlen = 8'd0; arburst = 2'b00; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ctrl", {24'd0, awready, wready, bvalid, arready, rvalid, rlast, 2'b00}, 32'd0);
    check_eq("rst_resp", {28'd0, bresp, rresp}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    resetn = 1'b1;
    #1;
    check_eq("ready_pre", {30'd0, awready, arready}, 32'd0);
    @(posedge clk); #1;
    check_eq("ready_post", {30'd0, awready, arready}, 32'd3);

    // Fill every word with a 256-beat INCR so the model starts fully known.
    for (int k = 0; k < 256; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(32'h0, 255, 2'b01, 1'b0, 0);
    do_read(32'h0, 255, 2'b01, -1);

    wd[0] = 32'd5; wd[1] = 32'd6; wd[2] = 32'd7; wd[3] = 32'd8;
    do_write(32'h04, 3, 2'b01, 1'b0, 5);
    do_read(32'h04, 3, 2'b01, 1);

    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    do_write(32'h18, 3, 2'b10, 1'b0, 0);
    do_read(32'h10, 3, 2'b01, 2);

    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(32'h0, 0, 2'b01, 1'b0, 0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    do_write(32'h0, 0, 2'b01, 1'b0, 0);
    do_read(32'h0, 0, 2'b01, -1);
    check_eq("strb_merge", last_rdata, 32'h11BB33DD);
    ws[0] = 4'hF;

    wd[0] = $urandom; wd[1] = $urandom;
    do_write(32'h3FC, 1, 2'b01, 1'b0, 0);
    do_read(32'h3FC, 1, 2'b01, -1);

    do_write(32'h20, 2, 2'b10, 1'b0, 0);
    do_read(32'h20, 2, 2'b10, -1);
    do_write(32'h60, 3, 2'b11, 1'b0, 0);
    do_read(32'h60, 3, 2'b11, -1);
    do_write(32'h70, 2, 2'b01, 1'b1, 0);
    do_write(32'h34, 3, 2'b00, 1'b0, 0);
    do_read(32'h30, 3, 2'b00, -1);

    // Reset while beat 2 of an 8-beat write is being offered; beats 0 and 1 must persist.
    for (int k = 0; k < 8; k++) wd[k] = $urandom;
    awaddr = 32'h80; awlen = 8'd7; awburst = 2'b01; awvalid = 1'b1;
    hs = 1'b0;
    for (int n = 0; n < 50 && !hs; n++) begin hs = awready; @(posedge clk); #1; end
    awvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wvalid = 1'b1; wdata = wd[k]; wstrb = 4'hF; wlast = 1'b0;
      hs = 1'b0;
      for (int n = 0; n < 50 && !hs; n++) begin hs = wready; @(posedge clk); #1; end
      model_mem[32 + k] = wd[k];
    end
    wdata = wd[2];
    resetn = 1'b0;
    #1;
    check_eq("rst_mid_ctrl", {24'd0, awready, wready, bvalid, arready, rvalid, rlast, 2'b00}, 32'd0);
    check_eq("rst_mid_resp", {28'd0, bresp, rresp}, 32'd0);
    check_eq("rst_mid_rdata", rdata, 32'd0);
    wvalid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mid_ready", {30'd0, awready, arready}, 32'd3);
    for (int k = 0; k < 4; k++) wd[k] = $urandom;
    do_write(32'h40, 3, 2'b01, 1'b0, 0);
    do_read(32'h80, 7, 2'b01, -1);

    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
      if (it % 3 == 2) begin
        a    = $urandom_range(0, 32'h1FC);
        a2   = $urandom_range(32'h240, 32'h3FC);
        len  = $urandom_range(0, 15);
        len2 = $urandom_range(0, 15);
        fork
          do_write(a, len, 2'b01, 1'b0, 0);
          do_read(a2, len2, 2'b01, -1);
        join
      end else begin
        b   = 2'($urandom_range(0, 3));
        len = pick_len(b);
        a   = $urandom_range(0, 32'h47F);
        do_write(a, len, b, 1'b0, $urandom_range(0, 2));
        b   = 2'($urandom_range(0, 3));
        len = pick_len(b);
        a   = $urandom_range(0, 32'h47F);
        do_read(a, len, b, $urandom_range(0, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
